// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the EX stage slice.
// Bus structs, stall polarity, divider state codes, funct codes.
package ex_stage_pkg;

  localparam int STALL_WD = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  localparam logic [5:0] FN_DIV  = 6'h1a;
  localparam logic [5:0] FN_DIVU = 6'h1b;

  // 159 bits, MSB first
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  src1;
    logic [3:0]  src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  // 76 bits
  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  // 38 bits
  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_fwd_t;

  // 65 bits
  typedef struct packed {
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// EX stage bus bundle: stall/ID input side, MEM/RF/HILO/SRAM outputs.
// slave = EX stage side, master = surrounding pipeline side.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [STALL_WD-1:0] stall;
  id_ex_t              id_to_ex_bus;
  ex_mem_t             ex_to_mem_bus;
  rf_fwd_t             ex_to_rf_bus;
  hilo_t               hilo_bus;
  logic                data_sram_en;
  logic [3:0]          data_sram_wen;
  logic [31:0]         data_sram_addr;
  logic [31:0]         data_sram_wdata;
  logic                stallreq_for_ex;

  modport master (
    output stall,
    output id_to_ex_bus,
    input  ex_to_mem_bus,
    input  ex_to_rf_bus,
    input  hilo_bus,
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    input  stallreq_for_ex
  );

  modport slave (
    input  stall,
    input  id_to_ex_bus,
    output ex_to_mem_bus,
    output ex_to_rf_bus,
    output hilo_bus,
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    output stallreq_for_ex
  );

endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU, one quotient bit per cycle.
// Ports: clk, rst, start, signed_op, a, b, flush, advance -> busy, done, q, r. Macro: DIV_ZERO_FAST_EN.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        advance,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  localparam int CW = $clog2(DIV_CYCLES);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   rem;
  logic [31:0]   quo;
  logic [31:0]   dvs;
  logic [31:0]   a_raw;
  logic          q_neg;
  logic          r_neg;
  logic          b_zero;

  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] shl;
  logic [33:0] diff;
  logic        fast_zero;

  assign a_abs = (signed_op && a[31]) ? -a : a;
  assign b_abs = (signed_op && b[31]) ? -b : b;

  // shift in next dividend bit, trial-subtract
  assign shl  = {rem, quo[31]};
  assign diff = {1'b0, shl} - {2'b0, dvs};

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = (b == 32'd0);
`else
  assign fast_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      a_raw  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= a_abs;
            dvs    <= b_abs;
            a_raw  <= a;
            q_neg  <= signed_op & (a[31] ^ b[31]);
            r_neg  <= signed_op & a[31];
            b_zero <= (b == 32'd0);
            state  <= fast_zero ? DIV_DONE
                                : DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (!diff[33]) begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= shl[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DIV_CYCLES - 1))
            state <= DIV_DONE;
        end
        DIV_DONE: begin
          // hold result until EX takes a new instr
          if (advance)
            state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign done = (state == DIV_DONE);
  assign busy = (state == DIV_IDLE && start)
             || (state == DIV_BUSY);

  always_comb begin
    q = '0;
    r = '0;
    if (done) begin
      if (b_zero) begin
        q = '1;
        r = a_raw;
      end else begin
        q = q_neg ? -quo : quo;
        r = r_neg ? -rem : rem;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// EX stage: ID/EX register, one-hot ALU, data SRAM request, DIV/DIVU via ex_div.
// Ports: clk, rst, bus (ex_stage_if.slave). Macro DIV_ZERO_FAST_EN passes to ex_div.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);

  id_ex_t ex_r;
  logic   bubble;
  logic   advance;

  assign bubble  = (bus.stall[2] == STOP)
                && (bus.stall[3] == NO_STOP);
  assign advance = (bus.stall[2] == NO_STOP);

  always_ff @(posedge clk) begin
    if (rst)
      ex_r <= '0;
    else if (bubble)
      ex_r <= '0;
    else if (advance)
      ex_r <= bus.id_to_ex_bus;
  end

  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic [31:0] sa;
  logic [31:0] src1;
  logic [31:0] src2;

  assign imm_s = sext16(ex_r.inst[15:0]);
  assign imm_z = {16'b0, ex_r.inst[15:0]};
  assign sa    = {27'b0, ex_r.inst[10:6]};

  assign src1 = ({32{ex_r.src1[0]}} & ex_r.rdata1)
              | ({32{ex_r.src1[1]}} & ex_r.pc)
              | ({32{ex_r.src1[2]}} & sa);

  assign src2 = ({32{ex_r.src2[0]}} & ex_r.rdata2)
              | ({32{ex_r.src2[1]}} & imm_s)
              | ({32{ex_r.src2[2]}} & 32'd8)
              | ({32{ex_r.src2[3]}} & imm_z);

  logic [11:0] op;
  logic [31:0] alu_res;

  assign op = ex_r.alu_op;

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      op[11]: alu_res = src1 + src2;
      op[10]: alu_res = src1 - src2;
      op[9]:  alu_res = {31'b0,
                $signed(src1) < $signed(src2)};
      op[8]:  alu_res = {31'b0, src1 < src2};
      op[7]:  alu_res = src1 & src2;
      op[6]:  alu_res = ~(src1 | src2);
      op[5]:  alu_res = src1 | src2;
      op[4]:  alu_res = src1 ^ src2;
      op[3]:  alu_res = src2 << src1[4:0];
      op[2]:  alu_res = src2 >> src1[4:0];
      op[1]:  alu_res = $signed(src2) >>> src1[4:0];
      op[0]:  alu_res = {src2[15:0], 16'b0};
      default: alu_res = '0;
    endcase
  end

  logic        is_div;
  logic        div_signed;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  assign div_signed = (ex_r.inst[5:0] == FN_DIV);
  assign is_div = (ex_r.inst[31:26] == 6'b0)
               && (div_signed
                || ex_r.inst[5:0] == FN_DIVU);

  ex_div #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (is_div),
    .signed_op(div_signed),
    .a        (ex_r.rdata1),
    .b        (ex_r.rdata2),
    .flush    (bubble),
    .advance  (advance),
    .busy     (div_busy),
    .done     (div_done),
    .q        (div_q),
    .r        (div_r)
  );

  assign bus.ex_to_mem_bus = '{
    pc:         ex_r.pc,
    ram_en:     ex_r.ram_en,
    ram_wen:    ex_r.ram_wen,
    sel_rf_res: ex_r.sel_rf_res,
    rf_we:      ex_r.rf_we,
    rf_waddr:   ex_r.rf_waddr,
    ex_result:  alu_res
  };

  // loads resolve in MEM; never forward them
  assign bus.ex_to_rf_bus = '{
    we:    ex_r.rf_we & ~ex_r.sel_rf_res,
    waddr: ex_r.rf_waddr,
    wdata: alu_res
  };

  assign bus.hilo_bus = '{
    we: div_done,
    hi: div_r,
    lo: div_q
  };

  assign bus.data_sram_en    = ex_r.ram_en;
  assign bus.data_sram_wen   = ex_r.ram_wen;
  assign bus.data_sram_addr  = ex_r.rdata1 + imm_s;
  assign bus.data_sram_wdata = ex_r.rdata2;
  assign bus.stallreq_for_ex = div_busy;

  logic unused;
  assign unused = ^{bus.stall[1:0],
                    bus.stall[5:4],
                    ex_r.inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
// Drives bus at negedge, samples at the following negedge.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;

  localparam logic [5:0] HOLD   = 6'b001111;
  localparam logic [5:0] BUBBLE = 6'b000111;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  ex_stage_if bus ();

  ex_stage #(
    .DIV_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic [31:0] inst;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  function automatic id_ex_t mk(
    input logic [11:0] op,
    input logic [2:0]  s1,
    input logic [3:0]  s2,
    input logic [31:0] inst,
    input logic [31:0] r1,
    input logic [31:0] r2
  );
    id_ex_t t;
    t = '0;
    t.pc = 32'hBFC0_0000;
    t.alu_op = op;
    t.src1 = s1;
    t.src2 = s2;
    t.inst = inst;
    t.rdata1 = r1;
    t.rdata2 = r2;
    return t;
  endfunction

  function automatic id_ex_t mk_div(
    input logic        sgn,
    input logic [31:0] r1,
    input logic [31:0] r2
  );
    logic [31:0] inst;
    inst = {6'b0, 5'd4, 5'd5, 10'b0,
            sgn ? FN_DIV : FN_DIVU};
    return mk(12'h0, 3'b001, 4'b0001,
              inst, r1, r2);
  endfunction

  task automatic apply(input id_ex_t ins);
    bus.id_to_ex_bus = ins;
    bus.stall = '0;
    @(negedge clk);
  endtask

  task automatic release_pipe();
    bus.id_to_ex_bus = '0;
    bus.stall = '0;
    @(negedge clk);
  endtask

  // load a div, then freeze the pipe and
  // count cycles with stallreq high
  task automatic run_div(
    input  id_ex_t ins,
    output int     n
  );
    bus.id_to_ex_bus = ins;
    bus.stall = '0;
    @(negedge clk);
    bus.stall = HOLD;
    n = 0;
    while (bus.stallreq_for_ex === 1'b1
           && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.stall = '0;
    bus.id_to_ex_bus = mk(OP_ADD, 3'b001,
      4'b0010, 32'h2422_FFFF, 5, 6);
    bus.id_to_ex_bus.rf_we = 1'b1;
    bus.id_to_ex_bus.ram_en = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.ex_to_mem_bus !== '0) begin
      bad++;
      $display("FAIL rst mem_bus got=%h want=0",
               bus.ex_to_mem_bus);
    end
    total++;
    if (bus.ex_to_rf_bus !== '0) begin
      bad++;
      $display("FAIL rst rf_bus got=%h want=0",
               bus.ex_to_rf_bus);
    end
    total++;
    if (bus.hilo_bus !== '0) begin
      bad++;
      $display("FAIL rst hilo got=%h want=0",
               bus.hilo_bus);
    end
    total++;
    if (bus.stallreq_for_ex !== 1'b0) begin
      bad++;
      $display("FAIL rst stallreq got=%b want=0",
               bus.stallreq_for_ex);
    end
    total++;
    if (bus.data_sram_en !== 1'b0) begin
      bad++;
      $display("FAIL rst sram_en got=%b want=0",
               bus.data_sram_en);
    end
    rst = 1'b0;
    release_pipe();
  endtask

  task automatic test_addiu();
    id_ex_t ins;
    ins = mk(OP_ADD, 3'b001, 4'b0010,
             {6'b001001, 5'd1, 5'd2, 16'hFFFF},
             32'd5, 32'd0);
    ins.rf_we = 1'b1;
    ins.rf_waddr = 5'd2;
    apply(ins);
    total++;
    if (bus.ex_to_mem_bus.ex_result !== 32'd4) begin
      bad++;
      $display("FAIL addiu res got=%h want=4",
               bus.ex_to_mem_bus.ex_result);
    end
    total++;
    if (bus.ex_to_rf_bus !== {1'b1, 5'd2, 32'd4})
    begin
      bad++;
      $display("FAIL addiu fwd got=%h want=%h",
               bus.ex_to_rf_bus,
               {1'b1, 5'd2, 32'd4});
    end
  endtask

  task automatic test_slt();
    apply(mk(OP_SLT, 3'b001, 4'b0001, 32'h0,
             32'hFFFF_FFFF, 32'd1));
    total++;
    if (bus.ex_to_mem_bus.ex_result !== 32'd1) begin
      bad++;
      $display("FAIL slt got=%h want=1",
               bus.ex_to_mem_bus.ex_result);
    end
    apply(mk(OP_SLTU, 3'b001, 4'b0001, 32'h0,
             32'hFFFF_FFFF, 32'd1));
    total++;
    if (bus.ex_to_mem_bus.ex_result !== 32'd0) begin
      bad++;
      $display("FAIL sltu got=%h want=0",
               bus.ex_to_mem_bus.ex_result);
    end
  endtask

  task automatic test_alu_ops();
    vecs[0]  = '{OP_SUB, 3'b001, 4'b0001, 32'h0,
                 32'd3, 32'd5, 32'hFFFF_FFFE};
    vecs[1]  = '{OP_AND, 3'b001, 4'b0001, 32'h0,
                 32'hF0F0_1234, 32'h0FF0_FFFF,
                 32'h00F0_1234};
    vecs[2]  = '{OP_NOR, 3'b001, 4'b0001, 32'h0,
                 32'h0000_00FF, 32'hF000_0000,
                 32'h0FFF_FF00};
    vecs[3]  = '{OP_OR, 3'b001, 4'b1000,
                 32'h3400_8001, 32'h1200_0000,
                 32'h0, 32'h1200_8001};
    vecs[4]  = '{OP_XOR, 3'b001, 4'b0001, 32'h0,
                 32'hFFFF_0000, 32'h0F0F_0F0F,
                 32'hF0F0_0F0F};
    vecs[5]  = '{OP_SLL, 3'b100, 4'b0001,
                 32'h0000_0100, 32'h0,
                 32'h8000_0001, 32'h0000_0010};
    vecs[6]  = '{OP_SRA, 3'b100, 4'b0001,
                 32'h0000_0100, 32'h0,
                 32'h8000_0010, 32'hF800_0001};
    vecs[7]  = '{OP_SRL, 3'b100, 4'b0001,
                 32'h0000_0100, 32'h0,
                 32'h8000_0010, 32'h0800_0001};
    vecs[8]  = '{OP_LUI, 3'b000, 4'b0010,
                 32'h3C00_8001, 32'h0, 32'h0,
                 32'h8001_0000};
    vecs[9]  = '{12'h000, 3'b001, 4'b0001, 32'h0,
                 32'd5, 32'd6, 32'h0};
    vecs[10] = '{OP_ADD, 3'b010, 4'b0100, 32'h0,
                 32'h0, 32'h0, 32'hBFC0_0008};
    for (int i = 0; i < 11; i++) begin
      apply(mk(vecs[i].op, vecs[i].s1, vecs[i].s2,
               vecs[i].inst, vecs[i].r1,
               vecs[i].r2));
      total++;
      if (bus.ex_to_mem_bus.ex_result
          !== vecs[i].exp) begin
        bad++;
        $display("FAIL alu[%0d] got=%h want=%h", i,
                 bus.ex_to_mem_bus.ex_result,
                 vecs[i].exp);
      end
    end
  endtask

  task automatic test_mem();
    id_ex_t ins;
    ins = mk(OP_ADD, 3'b001, 4'b0010,
             {6'b101011, 5'd1, 5'd2, 16'hFFFC},
             32'h0000_1000, 32'hDEAD_BEEF);
    ins.ram_en = 1'b1;
    ins.ram_wen = 4'hF;
    apply(ins);
    total++;
    if (bus.data_sram_addr !== 32'h0000_0FFC) begin
      bad++;
      $display("FAIL sw addr got=%h want=00000ffc",
               bus.data_sram_addr);
    end
    total++;
    if ({bus.data_sram_en, bus.data_sram_wen,
         bus.data_sram_wdata}
        !== {1'b1, 4'hF, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL sw ctl got=%b %h %h",
               bus.data_sram_en, bus.data_sram_wen,
               bus.data_sram_wdata);
    end
    ins.ram_wen = 4'h0;
    ins.rf_we = 1'b1;
    ins.rf_waddr = 5'd9;
    ins.sel_rf_res = 1'b1;
    apply(ins);
    total++;
    if (bus.ex_to_rf_bus.we !== 1'b0) begin
      bad++;
      $display("FAIL lw fwd_we got=%b want=0",
               bus.ex_to_rf_bus.we);
    end
    total++;
    if ({bus.ex_to_mem_bus.rf_we,
         bus.ex_to_mem_bus.sel_rf_res,
         bus.ex_to_mem_bus.rf_waddr}
        !== {1'b1, 1'b1, 5'd9}) begin
      bad++;
      $display("FAIL lw mem_bus got=%h",
               bus.ex_to_mem_bus);
    end
  endtask

  task automatic test_div_signed();
    int n;
    run_div(mk_div(1'b1, 32'd7, 32'hFFFF_FFFE), n);
    total++;
    if (n != 33) begin
      bad++;
      $display("FAIL div lat got=%0d want=33", n);
    end
    total++;
    if (bus.hilo_bus
        !== {1'b1, 32'd1, 32'hFFFF_FFFD}) begin
      bad++;
      $display("FAIL div hilo got=%h want=%h",
               bus.hilo_bus,
               {1'b1, 32'd1, 32'hFFFF_FFFD});
    end
  endtask

  // continues from DONE of test_div_signed
  task automatic test_done_hold();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.hilo_bus
          !== {1'b1, 32'd1, 32'hFFFF_FFFD}) begin
        bad++;
        $display("FAIL hold[%0d] hilo got=%h",
                 i, bus.hilo_bus);
      end
      total++;
      if (bus.stallreq_for_ex !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d] stallreq got=%b",
                 i, bus.stallreq_for_ex);
      end
    end
    release_pipe();
    total++;
    if (bus.hilo_bus.we !== 1'b0) begin
      bad++;
      $display("FAIL hold rel hilo_we got=%b want=0",
               bus.hilo_bus.we);
    end
    total++;
    if (dut.u_div.state !== 2'd0) begin
      bad++;
      $display("FAIL hold rel state got=%0d want=0",
               dut.u_div.state);
    end
  endtask

  task automatic test_div_zero();
    int n;
    run_div(mk_div(1'b0, 32'd9, 32'd0), n);
    total++;
    if (n != ZERO_LAT) begin
      bad++;
      $display("FAIL divz lat got=%0d want=%0d",
               n, ZERO_LAT);
    end
    total++;
    if (bus.hilo_bus
        !== {1'b1, 32'd9, 32'hFFFF_FFFF}) begin
      bad++;
      $display("FAIL divz hilo got=%h want=%h",
               bus.hilo_bus,
               {1'b1, 32'd9, 32'hFFFF_FFFF});
    end
    release_pipe();
  endtask

  task automatic test_div_ovf();
    int n;
    run_div(mk_div(1'b1, 32'h8000_0000,
                   32'hFFFF_FFFF), n);
    total++;
    if (n != 33) begin
      bad++;
      $display("FAIL ovf lat got=%0d want=33", n);
    end
    total++;
    if (bus.hilo_bus
        !== {1'b1, 32'd0, 32'h8000_0000}) begin
      bad++;
      $display("FAIL ovf hilo got=%h want=%h",
               bus.hilo_bus,
               {1'b1, 32'd0, 32'h8000_0000});
    end
    release_pipe();
  endtask

  task automatic test_back_to_back();
    int n;
    run_div(mk_div(1'b0, 32'd100, 32'd7), n);
    total++;
    if (bus.hilo_bus
        !== {1'b1, 32'd2, 32'd14}) begin
      bad++;
      $display("FAIL b2b1 hilo got=%h want=%h",
               bus.hilo_bus,
               {1'b1, 32'd2, 32'd14});
    end
    // second div issued straight out of DONE
    run_div(mk_div(1'b1, 32'hFFFF_FFF9, 32'd2), n);
    total++;
    if (n != 33) begin
      bad++;
      $display("FAIL b2b2 lat got=%0d want=33", n);
    end
    total++;
    if (bus.hilo_bus !== {1'b1, 32'hFFFF_FFFF,
                          32'hFFFF_FFFD}) begin
      bad++;
      $display("FAIL b2b2 hilo got=%h want=%h",
               bus.hilo_bus,
               {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    release_pipe();
  endtask

  task automatic test_rst_mid_busy();
    int n;
    bus.id_to_ex_bus = mk_div(1'b0, 32'd1000, 32'd3);
    bus.stall = '0;
    @(negedge clk);
    bus.stall = HOLD;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.stallreq_for_ex !== 1'b0) begin
      bad++;
      $display("FAIL rstb stallreq got=%b want=0",
               bus.stallreq_for_ex);
    end
    total++;
    if (dut.u_div.state !== 2'd0) begin
      bad++;
      $display("FAIL rstb state got=%0d want=0",
               dut.u_div.state);
    end
    total++;
    if ({bus.ex_to_mem_bus, bus.ex_to_rf_bus,
         bus.hilo_bus} !== '0) begin
      bad++;
      $display("FAIL rstb buses got=%h %h %h",
               bus.ex_to_mem_bus, bus.ex_to_rf_bus,
               bus.hilo_bus);
    end
    rst = 1'b0;
    run_div(mk_div(1'b1, 32'hFFFF_FFEC, 32'd6), n);
    total++;
    if (n != 33) begin
      bad++;
      $display("FAIL rsta lat got=%0d want=33", n);
    end
    total++;
    if (bus.hilo_bus !== {1'b1, 32'hFFFF_FFFE,
                          32'hFFFF_FFFD}) begin
      bad++;
      $display("FAIL rsta hilo got=%h want=%h",
               bus.hilo_bus,
               {1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD});
    end
    release_pipe();
  endtask

  task automatic test_bubble();
    bus.id_to_ex_bus = mk_div(1'b0, 32'd50, 32'd3);
    bus.stall = '0;
    @(negedge clk);
    bus.stall = HOLD;
    repeat (5) @(negedge clk);
    bus.stall = BUBBLE;
    @(negedge clk);
    total++;
    if (bus.stallreq_for_ex !== 1'b0) begin
      bad++;
      $display("FAIL bub stallreq got=%b want=0",
               bus.stallreq_for_ex);
    end
    total++;
    if ({dut.u_div.state, bus.hilo_bus.we}
        !== 3'b000) begin
      bad++;
      $display("FAIL bub state=%0d hilo_we=%b",
               dut.u_div.state, bus.hilo_bus.we);
    end
    release_pipe();
  endtask

  initial begin
    bus.stall = '0;
    bus.id_to_ex_bus = '0;
    test_reset();
    test_addiu();
    test_slt();
    test_alu_ops();
    test_mem();
    test_div_signed();
    test_done_hold();
    test_div_zero();
    test_div_ovf();
    test_back_to_back();
    test_rst_mid_busy();
    test_bubble();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
